muldiv_sequencer: RTL

Iterative multiply/divide controller for the pipelined MIPS core. It sits beside the Execute stage, accepts MULT/MULTU/DIV/DIVU operations from E, runs them over DWL+1 cycles on a shared shift/add datapath, and owns the HI/LO registers. It raises a stall request, ORed into the pipeline's global Stall, while a later instruction needs HI/LO or the unit.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_iter.sv | 34 +++
 rtl/muldiv_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  // Bit 1 of the opcode selects divide, bit 0 selects signed.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One shift/add (multiply) or shift/subtract (restoring divide) step.
module muldiv_iter #(
  parameter int unsigned DWL = 32
) (
  input  logic           is_div,
  input  logic [DWL-1:0] hi,
  input  logic [DWL-1:0] lo,
  input  logic [DWL-1:0] operand,
  output logic [DWL-1:0] hi_nxt,
  output logic [DWL-1:0] lo_nxt
);

  logic [DWL:0] mul_sum;
  logic [DWL:0] shifted;
  logic         qbit;

  // Multiply consumes the multiplier LSB first from lo; divide shifts the
  // dividend MSB first out of lo and the quotient bit in at the bottom.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, operand} : (DWL + 1)'(0));
    shifted = {hi, lo[DWL-1]};
    qbit    = (shifted >= {1'b0, operand});
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (is_div) begin
      hi_nxt = qbit ? DWL'(shifted - {1'b0, operand}) : shifted[DWL-1:0];
      lo_nxt = {lo[DWL-2:0], qbit};
    end else begin
      hi_nxt = mul_sum[DWL:1];
      lo_nxt = {mul_sum[0], lo[DWL-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning the HI/LO registers.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned DWL = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           StartE,
  input  logic [1:0]     OpE,
  input  logic [DWL-1:0] SrcAE,
  input  logic [DWL-1:0] SrcBE,
  input  logic           HiLoReadD,
  input  logic           MDReqD,
  output logic           Busy,
  output logic           StallMD,
  output logic           Done,
  output logic [DWL-1:0] HI,
  output logic [DWL-1:0] LO
);

  localparam int unsigned CW = $clog2(DWL) + 1;
  localparam int unsigned PW = 2 * DWL;

  state_e         state;
  op_e            op;
  logic           sign_a;
  logic           sign_b;
  logic           dz;
  logic [DWL-1:0] mag_a;
  logic [DWL-1:0] operand;
  logic [DWL-1:0] acc_hi;
  logic [DWL-1:0] acc_lo;
  logic [CW-1:0]  cnt;

  logic           start_signed;
  logic [DWL-1:0] start_mag_a;
  logic [DWL-1:0] start_mag_b;
  logic [DWL-1:0] hi_nxt;
  logic [DWL-1:0] lo_nxt;
  logic [DWL-1:0] fix_hi;
  logic [DWL-1:0] fix_lo;
  logic [PW-1:0]  prod_neg;

  muldiv_iter #(.DWL(DWL)) u_iter (
    .is_div  (op_is_div(op)),
    .hi      (acc_hi),
    .lo      (acc_lo),
    .operand (operand),
    .hi_nxt  (hi_nxt),
    .lo_nxt  (lo_nxt)
  );

  // Operand magnitudes taken at issue; unsigned ops pass through untouched.
  always_comb begin
    start_signed = op_is_signed(op_e'(OpE));
    start_mag_a  = (start_signed && SrcAE[DWL-1]) ? DWL'(0) - SrcAE : SrcAE;
    start_mag_b  = (start_signed && SrcBE[DWL-1]) ? DWL'(0) - SrcBE : SrcBE;
  end

  // Sign correction and divide-by-zero override applied on the SIGN cycle.
  always_comb begin
    prod_neg = PW'(0) - {acc_hi, acc_lo};
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    if (op_is_div(op)) begin
      if (dz) begin
        fix_lo = '1;
        fix_hi = sign_a ? DWL'(0) - mag_a : mag_a;
      end else begin
        fix_lo = (sign_a ^ sign_b) ? DWL'(0) - acc_lo : acc_lo;
        fix_hi = sign_a ? DWL'(0) - acc_hi : acc_hi;
      end
    end else if (sign_a ^ sign_b) begin
      fix_hi = prod_neg[PW-1:DWL];
      fix_lo = prod_neg[DWL-1:0];
    end
  end

  // Sequencer FSM, iteration datapath registers and HI/LO ownership.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      op      <= OP_MULTU;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      dz      <= 1'b0;
      mag_a   <= '0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      Done    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (StartE) begin
            op     <= op_e'(OpE);
            sign_a <= start_signed & SrcAE[DWL-1];
            sign_b <= start_signed & SrcBE[DWL-1];
            dz     <= (SrcBE == '0);
            mag_a  <= start_mag_a;
            acc_hi <= '0;
            cnt    <= CW'(DWL);
            state  <= S_RUN;
            if (op_is_div(op_e'(OpE))) begin
              operand <= start_mag_b;
              acc_lo  <= start_mag_a;
            end else begin
              operand <= start_mag_a;
              acc_lo  <= start_mag_b;
            end
          end
        end
        S_RUN: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= S_SIGN;
          end
        end
        S_SIGN: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          Done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy    = (state != S_IDLE);
  assign StallMD = Busy & (HiLoReadD | MDReqD);

endmodule
